// File: rtl/clock_pkg.sv
// Shared definitions for the BCD clock counters.
//   DIG_W      : width of one BCD digit
//   digit_t    : one BCD digit
//   bcd2_t     : two-digit BCD value {h = tens, l = units}
//   to_bcd     : constant conversion of a small integer to a digit pair
//   bcd_valid  : both nibbles hold a decimal digit
//   bcd_le     : digit-wise a <= b, valid only for legal BCD operands
package clock_pkg;

  localparam int DIG_W = 4;

  typedef logic [DIG_W-1:0] digit_t;

  typedef struct packed {
    digit_t h;
    digit_t l;
  } bcd2_t;

  localparam digit_t DIGIT_MAX = 4'd9;
  localparam digit_t DIGIT_MIN = 4'd0;

  function automatic bcd2_t to_bcd(input int v);
    bcd2_t r;
    r.h = digit_t'(v / 10);
    r.l = digit_t'(v % 10);
    return r;
  endfunction

  function automatic logic bcd_valid(input digit_t h, input digit_t l);
    return (h <= DIGIT_MAX) && (l <= DIGIT_MAX);
  endfunction

  // Compare tens first, units only break a tie; avoids any binary conversion.
  function automatic logic bcd_le(input bcd2_t a, input bcd2_t b);
    return (a.h < b.h) || ((a.h == b.h) && (a.l <= b.l));
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single BCD digit increment/decrement.
//   digit_i     : current digit
//   dir_i       : 1 = increment, 0 = decrement
//   digit_max_i : highest digit value before wrapping
//   digit_min_i : lowest digit value before wrapping
//   digit_o     : stepped digit
//   carry_o     : wrap indicator (carry when counting up, borrow when down)
module bcd_digit_step
  import clock_pkg::*;
(
  input  logic [DIG_W-1:0] digit_i,
  input  logic             dir_i,
  input  logic [DIG_W-1:0] digit_max_i,
  input  logic [DIG_W-1:0] digit_min_i,
  output logic [DIG_W-1:0] digit_o,
  output logic             carry_o
);

  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (dir_i) begin
      // >= rather than == so an out-of-range digit still wraps cleanly
      if (digit_i >= digit_max_i) begin
        digit_o = digit_min_i;
        carry_o = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
      end
    end else begin
      if (digit_i <= digit_min_i) begin
        digit_o = digit_max_i;
        carry_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down count, validated preset load
// and a combinational terminal-count output for cascading.
//   clk      : system clock, rising edge
//   cr       : synchronous active-high clear to MIN_VAL
//   en       : count enable (usually the lower stage's co)
//   up       : 1 = count up, 0 = count down
//   load     : synchronous preset strobe
//   din_h/l  : preset tens/units digits
//   out_h/l  : registered count digits
//   co       : terminal count, high in the cycle that wraps
//   load_err : sticky, set by a rejected load, cleared by a good load or cr
// Edge priority: cr > load > en > hold.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULO  = 24,
  parameter int MIN_VAL = 0
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [DIG_W-1:0] din_h,
  input  logic [DIG_W-1:0] din_l,
  output logic [DIG_W-1:0] out_h,
  output logic [DIG_W-1:0] out_l,
  output logic             co,
  output logic             load_err
);

  localparam int MAX_VAL = MIN_VAL + MODULO - 1;

  if ((MODULO < 2) || (MODULO > 99) || ((MIN_VAL != 0) && (MIN_VAL != 1)) ||
      (MAX_VAL > 99)) begin : g_param_check
    $error("bcd_mod_counter: illegal MODULO/MIN_VAL combination");
  end

  localparam bcd2_t MIN_BCD = to_bcd(MIN_VAL);
  localparam bcd2_t MAX_BCD = to_bcd(MAX_VAL);

  bcd2_t  cnt_q, cnt_d;
  logic   err_q, err_d;
  bcd2_t  din_bcd;
  logic   at_max, at_min, cur_legal, din_ok;
  digit_t lo_step, hi_step;
  logic   lo_carry;
  logic   hi_carry_unused;

  assign din_bcd = {din_h, din_l};

  assign at_max = (cnt_q == MAX_BCD);
  assign at_min = (cnt_q == MIN_BCD);

  // Nibble check first: bcd_le is only meaningful on decimal digits.
  assign cur_legal = bcd_valid(cnt_q.h, cnt_q.l) &&
                     bcd_le(MIN_BCD, cnt_q) && bcd_le(cnt_q, MAX_BCD);
  assign din_ok    = bcd_valid(din_h, din_l) &&
                     bcd_le(MIN_BCD, din_bcd) && bcd_le(din_bcd, MAX_BCD);

  bcd_digit_step u_units (
    .digit_i     (cnt_q.l),
    .dir_i       (up),
    .digit_max_i (DIGIT_MAX),
    .digit_min_i (DIGIT_MIN),
    .digit_o     (lo_step),
    .carry_o     (lo_carry)
  );

  // Tens never wraps on its own: the MAX/MIN override below catches the
  // only case where it would, so its carry is not needed.
  bcd_digit_step u_tens (
    .digit_i     (cnt_q.h),
    .dir_i       (up),
    .digit_max_i (DIGIT_MAX),
    .digit_min_i (DIGIT_MIN),
    .digit_o     (hi_step),
    .carry_o     (hi_carry_unused)
  );

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (load) begin
      if (din_ok) begin
        cnt_d = din_bcd;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (!cur_legal) begin
        cnt_d = MIN_BCD;
      end else if (up && at_max) begin
        cnt_d = MIN_BCD;
      end else if (!up && at_min) begin
        cnt_d = MAX_BCD;
      end else begin
        cnt_d.l = lo_step;
        if (lo_carry) begin
          cnt_d.h = hi_step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      cnt_q <= MIN_BCD;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out_h    = cnt_q.h;
  assign out_l    = cnt_q.l;
  assign load_err = err_q;

  // Combinational so the next stage's en sees it in the same cycle.
  assign co = en & ~cr & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  logic       clk;
  logic       cr_s   [4];
  logic       en_s   [4];
  logic       up_s   [4];
  logic       load_s [4];
  logic [3:0] dh_s   [4];
  logic [3:0] dl_s   [4];
  logic [3:0] oh_s   [5];
  logic [3:0] ol_s   [5];
  logic       co_s   [5];
  logic       le_s   [5];

  typedef struct {
    int id;
    int val;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   mval [5];
  bit   merr [5];
  bit   mco  [5];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: mod 24 from 0, 1: mod 12 from 1, 2: mod 60, 3/4: cascaded mod 60 low/high
  bcd_mod_counter #(.MODULO(24), .MIN_VAL(0)) u_d24 (
    .clk(clk), .cr(cr_s[0]), .en(en_s[0]), .up(up_s[0]), .load(load_s[0]),
    .din_h(dh_s[0]), .din_l(dl_s[0]), .out_h(oh_s[0]), .out_l(ol_s[0]),
    .co(co_s[0]), .load_err(le_s[0]));
  bcd_mod_counter #(.MODULO(12), .MIN_VAL(1)) u_d12 (
    .clk(clk), .cr(cr_s[1]), .en(en_s[1]), .up(up_s[1]), .load(load_s[1]),
    .din_h(dh_s[1]), .din_l(dl_s[1]), .out_h(oh_s[1]), .out_l(ol_s[1]),
    .co(co_s[1]), .load_err(le_s[1]));
  bcd_mod_counter #(.MODULO(60), .MIN_VAL(0)) u_d60 (
    .clk(clk), .cr(cr_s[2]), .en(en_s[2]), .up(up_s[2]), .load(load_s[2]),
    .din_h(dh_s[2]), .din_l(dl_s[2]), .out_h(oh_s[2]), .out_l(ol_s[2]),
    .co(co_s[2]), .load_err(le_s[2]));
  bcd_mod_counter #(.MODULO(60), .MIN_VAL(0)) u_lo (
    .clk(clk), .cr(cr_s[3]), .en(en_s[3]), .up(up_s[3]), .load(load_s[3]),
    .din_h(dh_s[3]), .din_l(dl_s[3]), .out_h(oh_s[3]), .out_l(ol_s[3]),
    .co(co_s[3]), .load_err(le_s[3]));
  bcd_mod_counter #(.MODULO(60), .MIN_VAL(0)) u_hi (
    .clk(clk), .cr(cr_s[3]), .en(co_s[3]), .up(up_s[3]), .load(1'b0),
    .din_h(4'd0), .din_l(4'd0), .out_h(oh_s[4]), .out_l(ol_s[4]),
    .co(co_s[4]), .load_err(le_s[4]));

  function automatic int mn_of(input int id);
    return (id == 1) ? 1 : 0;
  endfunction

  function automatic int mx_of(input int id);
    return (id == 0) ? 23 : (id == 1) ? 12 : 59;
  endfunction

  function automatic logic [7:0] exp_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Integer reference model of one counter edge.
  function automatic void model_step(input int mn, input int mx, input bit c,
                                     input bit l, input bit e, input bit u,
                                     input int dh, input int dl,
                                     inout int v, inout bit er, output bit co);
    int dv;
    bit ok;
    dv = dh * 10 + dl;
    ok = (dh <= 9) && (dl <= 9) && (dv >= mn) && (dv <= mx);
    co = 1'b0;
    if (c) begin
      v  = mn;
      er = 1'b0;
    end else if (l) begin
      if (ok) begin
        v  = dv;
        er = 1'b0;
      end else begin
        er = 1'b1;
      end
    end else if (e) begin
      if (u) begin
        co = (v == mx);
        v  = (v == mx) ? mn : v + 1;
      end else begin
        co = (v == mn);
        v  = (v == mn) ? mx : v - 1;
      end
    end
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      cr_s[i] = 1'b0; load_s[i] = 1'b0; en_s[i] = 1'b0; up_s[i] = 1'b1;
      dh_s[i] = 4'd0; dl_s[i] = 4'd0;
    end
  endtask

  // Drive one counter for the coming edge and queue its expected state.
  task automatic apply(input int id, input bit c, input bit l, input bit e,
                       input bit u, input int dh, input int dl);
    exp_t x;
    int   v;
    bit   er, co;
    cr_s[id] = c; load_s[id] = l; en_s[id] = e; up_s[id] = u;
    dh_s[id] = 4'(dh); dl_s[id] = 4'(dl);
    v = mval[id]; er = merr[id];
    model_step(mn_of(id), mx_of(id), c, l, e, u, dh, dl, v, er, co);
    mval[id] = v; merr[id] = er; mco[id] = co;
    x.id = id; x.val = v; x.err = er;
    sb.push_back(x);
    if (id == 3) begin
      v = mval[4]; er = merr[4];
      model_step(0, 59, c, 1'b0, mco[3], u, 0, 0, v, er, co);
      mval[4] = v; merr[4] = er; mco[4] = co;
      x.id = 4; x.val = v; x.err = er;
      sb.push_back(x);
    end
  endtask

  task automatic test_reset();
    exp_t x;
    idle_all();
    for (int i = 0; i < 4; i++) apply(i, 1, 1, 1, 1, 1, 2);
    #1;
    foreach (sb[k]) begin
      checks++;
      if (co_s[sb[k].id] !== mco[sb[k].id]) begin
        errors++;
        $display("FAIL reset_co dut%0d: co=%b want %b", sb[k].id, co_s[sb[k].id], mco[sb[k].id]);
      end
    end
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
        errors++;
        $display("FAIL reset dut%0d: out=%h%h err=%b want %0d err=%b",
                 x.id, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
      end
    end
    idle_all();
  endtask

  task automatic test_count24();
    exp_t x;
    for (int i = 0; i < 24; i++) begin
      apply(0, 0, 0, 1, 1, 0, 0);
      #1;
      checks++;
      if (co_s[0] !== mco[0]) begin
        errors++;
        $display("FAIL count24_co step%0d: co=%b want %b", i, co_s[0], mco[0]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL count24 step%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      checks++;
      if (oh_s[0] > 4'd2) begin
        errors++;
        $display("FAIL count24_tens step%0d: out_h=%h want <= 2", i, oh_s[0]);
      end
      idle_all();
    end
  endtask

  task automatic test_count12();
    exp_t x;
    for (int i = 0; i < 15; i++) begin
      apply(1, 0, 0, 1, (i < 12), 0, 0);
      #1;
      checks++;
      if (co_s[1] !== mco[1]) begin
        errors++;
        $display("FAIL count12_co step%0d: co=%b want %b", i, co_s[1], mco[1]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL count12 step%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      idle_all();
    end
  endtask

  task automatic test_down60();
    exp_t x;
    // c, l, e, u, dh, dl
    int tab [6][6] = '{'{0,1,0,0,1,0}, '{0,0,1,0,0,0}, '{0,0,1,0,0,0},
                       '{0,1,0,0,0,0}, '{0,0,1,0,0,0}, '{0,0,1,0,0,0}};
    for (int i = 0; i < 6; i++) begin
      apply(2, tab[i][0] != 0, tab[i][1] != 0, tab[i][2] != 0, tab[i][3] != 0,
            tab[i][4], tab[i][5]);
      #1;
      checks++;
      if (co_s[2] !== mco[2]) begin
        errors++;
        $display("FAIL down60_co row%0d: co=%b want %b", i, co_s[2], mco[2]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL down60 row%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      idle_all();
    end
  endtask

  task automatic test_load();
    exp_t x;
    int tab [4][2] = '{'{1,5}, '{1,10}, '{2,5}, '{0,7}};
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1, 0, 1, tab[i][0], tab[i][1]);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL load row%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      idle_all();
    end
  endtask

  task automatic test_simultaneous();
    exp_t x;
    int tab [8][6] = '{'{1,1,1,1,1,2}, '{0,1,0,1,2,3}, '{0,1,1,1,0,5},
                       '{0,0,0,1,0,0}, '{0,0,0,0,0,0}, '{0,0,0,1,0,0},
                       '{0,0,0,0,0,0}, '{0,0,0,1,0,0}};
    for (int i = 0; i < 8; i++) begin
      apply(0, tab[i][0] != 0, tab[i][1] != 0, tab[i][2] != 0, tab[i][3] != 0,
            tab[i][4], tab[i][5]);
      #1;
      checks++;
      if (co_s[0] !== mco[0]) begin
        errors++;
        $display("FAIL simul_co row%0d: co=%b want %b", i, co_s[0], mco[0]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL simul row%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      idle_all();
    end
  endtask

  task automatic test_cascade();
    exp_t x;
    int   hi_co_cnt = 0;
    for (int i = -1; i < 3600; i++) begin
      if (i < 0) apply(3, 1, 0, 0, 1, 0, 0);
      else       apply(3, 0, 0, 1, 1, 0, 0);
      #1;
      if (co_s[4] === 1'b1) hi_co_cnt++;
      checks++;
      if (co_s[3] !== mco[3] || co_s[4] !== mco[4]) begin
        errors++;
        $display("FAIL cascade_co step%0d: co lo/hi=%b/%b want %b/%b",
                 i, co_s[3], co_s[4], mco[3], mco[4]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL cascade step%0d dut%0d: out=%h%h err=%b want %0d err=%b",
                   i, x.id, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      if (i == 3598) begin
        checks++;
        if ({oh_s[4], ol_s[4], oh_s[3], ol_s[3]} !== 16'h5959) begin
          errors++;
          $display("FAIL cascade_top: got %h%h:%h%h want 59:59",
                   oh_s[4], ol_s[4], oh_s[3], ol_s[3]);
        end
      end
      idle_all();
    end
    checks++;
    if ({oh_s[4], ol_s[4], oh_s[3], ol_s[3]} !== 16'h0000) begin
      errors++;
      $display("FAIL cascade_wrap: got %h%h:%h%h want 00:00",
               oh_s[4], ol_s[4], oh_s[3], ol_s[3]);
    end
    checks++;
    if (hi_co_cnt != 1) begin
      errors++;
      $display("FAIL cascade_hi_co: count=%0d want 1", hi_co_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   dh, dl;
    bit   c, l, e, u;
    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) != 0;
      dh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      dl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      apply(0, c, l, e, u, dh, dl);
      #1;
      checks++;
      if (co_s[0] !== mco[0]) begin
        errors++;
        $display("FAIL b2b_co step%0d: co=%b want %b", i, co_s[0], mco[0]);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ({oh_s[x.id], ol_s[x.id]} !== exp_bcd(x.val) || le_s[x.id] !== x.err) begin
          errors++;
          $display("FAIL b2b step%0d: out=%h%h err=%b want %0d err=%b",
                   i, oh_s[x.id], ol_s[x.id], le_s[x.id], x.val, x.err);
        end
      end
      idle_all();
    end
  endtask

  initial begin
    idle_all();
    @(posedge clk); #1;
    test_reset();
    test_count24();
    test_count12();
    test_down60();
    test_load();
    test_simultaneous();
    test_cascade();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
